// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter: read-return owner tag,
// host handshake states and the bus direction encoding.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_HOST   = 2'd2
  } owner_e;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_DONE = 1'b1
  } hstate_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // A MAX_WAIT of 0 still needs a one-bit register to keep the port legal.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive cycles a pending host request has lost to
// the CPU; at_max forces the next host grant.
module dmem_arb_starve_ctr #(
  parameter int MAX = 4,
  parameter int CW  = 3
) (
  input  logic ck,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CW-1:0] cnt;

  assign at_max = (cnt == CW'(MAX));

  always_ff @(posedge ck or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !at_max)
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter between the CPU data port and the host loader.
// Define ARB_STATS_EN to add the saturating STAT_CONFLICT counter output.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          C_REQ,
  input  logic          C_RW,
  input  logic [AW-1:0] C_A,
  input  logic [DW-1:0] C_WD,
  output logic          C_WAIT,
  output logic          C_VALID,
  output logic [DW-1:0] C_RD,
  input  logic          H_REQ,
  input  logic          H_RW,
  input  logic [AW-1:0] H_A,
  input  logic [DW-1:0] H_WD,
  output logic          H_ACK,
  output logic [DW-1:0] H_RD,
`ifdef ARB_STATS_EN
  output logic [15:0]   STAT_CONFLICT,
`endif
  output logic          M_EN,
  output logic          M_RW,
  output logic [AW-1:0] M_A,
  output logic [DW-1:0] M_WD,
  input  logic [DW-1:0] M_RD
);

  localparam int CW = cnt_width(MAX_WAIT);

  hstate_e state, state_nx;
  owner_e  owner, owner_nx;
  logic    host_elig, host_urgent, host_grant, cpu_grant, at_max;

  dmem_arb_starve_ctr #(.MAX(MAX_WAIT), .CW(CW)) u_starve (
    .ck     (CK),
    .rst    (RST),
    .inc    (host_elig && !host_grant),
    .clr    (host_grant || !H_REQ),
    .at_max (at_max)
  );

  // Grants are qualified by RST so nothing reaches the macro while in reset.
  always_comb begin
    host_elig   = H_REQ && (state == H_IDLE);
    host_urgent = host_elig && at_max;
    host_grant  = RST && (host_urgent || (host_elig && !C_REQ));
    cpu_grant   = RST && C_REQ && !host_grant;
    C_WAIT      = C_REQ && !cpu_grant;

    M_EN = host_grant || cpu_grant;
    M_RW = RW_READ;
    M_A  = '0;
    M_WD = '0;
    if (host_grant) begin
      M_RW = H_RW;
      M_A  = H_A;
      M_WD = H_WD;
    end else if (cpu_grant) begin
      M_RW = C_RW;
      M_A  = C_A;
      M_WD = C_WD;
    end

    state_nx = state;
    case (state)
      H_IDLE:  if (host_grant) state_nx = H_DONE;
      H_DONE:  state_nx = H_IDLE;
      default: state_nx = H_IDLE;
    endcase

    owner_nx = OWN_NONE;
    if (host_grant && H_RW == RW_READ)
      owner_nx = OWN_HOST;
    else if (cpu_grant && C_RW == RW_READ)
      owner_nx = OWN_CPU_RD;
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state <= H_IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end

  assign H_ACK   = (state == H_DONE);
  assign C_VALID = (owner == OWN_CPU_RD);
  assign C_RD    = C_VALID ? M_RD : '0;
  assign H_RD    = (owner == OWN_HOST) ? M_RD : '0;

`ifdef ARB_STATS_EN
  always_ff @(posedge CK or negedge RST) begin
    if (!RST)
      STAT_CONFLICT <= '0;
    else if (C_REQ && host_elig && STAT_CONFLICT != 16'hFFFF)
      STAT_CONFLICT <= STAT_CONFLICT + 16'd1;
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters:
  - the CPU data port (DA/DD/RW);
  - a host/debug loader port with a req/ack handshake.
- One memory access issued per cycle.
- CPU has default priority; a bounded starvation counter guarantees host progress.
- Sits between the CPU core, the DMEM macro and the host loader.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_WAIT, 4, max consecutive cycles a pending host request may lose to the CPU. 0 = host always wins.

Ports:
- CK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous active-low reset.
- C_REQ  in  1  CPU requests a data access this cycle.
- C_RW  in  1  CPU direction; 1=read, 0=write.
- C_A  in  AW  CPU address.
- C_WD  in  DW  CPU write data.
- C_WAIT  out  1  CPU request not issued this cycle; CPU holds its request and stalls.
- C_VALID  out  1  C_RD valid (cycle after an issued CPU read).
- C_RD  out  DW  CPU read data.
- H_REQ  in  1  host request; held stable until H_ACK.
- H_RW  in  1  host direction; 1=read, 0=write.
- H_A  in  AW  host address.
- H_WD  in  DW  host write data.
- H_ACK  out  1  one-cycle pulse: host access complete; H_RD valid if read.
- H_RD  out  DW  host read data.
- M_EN  out  1  memory access strobe.
- M_RW  out  1  memory direction; 1=read, 0=write.
- M_A  out  AW  memory address.
- M_WD  out  DW  memory write data.
- M_RD  in  DW  memory read data, valid one cycle after M_EN with M_RW=1.

Behaviour:
- Reset (RST=0, async): all state cleared.
  - H_ACK=0, C_VALID=0, starvation count=0, host FSM=H_IDLE, read owner=NONE.
  - M_EN=0 while RST=0.
- Host FSM:
  - H_IDLE: host request eligible. On host grant -> H_DONE.
  - H_DONE: H_ACK=1 for exactly one cycle; H_REQ ignored for arbitration this cycle. Unconditional -> H_IDLE.
  - The host may present a new request in the cycle after H_ACK.
- Grant, combinational per cycle:
  - host_eligible = H_REQ & state==H_IDLE.
  - host_urgent = host_eligible & cnt==MAX_WAIT.
  - Grant host if host_urgent, or if host_eligible & !C_REQ.
  - Otherwise grant CPU if C_REQ.
  - No grant: M_EN=0.
- Memory side:
  - M_EN/M_RW/M_A/M_WD are a combinational mux of the granted requester.
  - With no grant, M_A/M_WD hold 0.
- CPU stall: C_WAIT = C_REQ & !cpu_grant.
- Starvation counter (cnt, width clog2(MAX_WAIT+1)):
  - Increment when host_eligible and not granted.
  - Clear on host grant or when H_REQ=0.
  - Never exceeds MAX_WAIT.
- Read return:
  - Registered owner tag set at issue: CPU_RD, HOST, or NONE.
  - Next cycle: C_RD = M_RD with C_VALID=1 if tag=CPU_RD; H_RD = M_RD if tag=HOST.
  - At other times C_RD/H_RD drive 0.
- Latency:
  - Uncontended CPU access: issue in the request cycle, data the next cycle.
  - Uncontended host access: H_ACK one cycle after the request is first seen.
  - Worst case host: MAX_WAIT+1 cycles to grant.
- Writes: data committed at the issue edge; the write ack is the same H_DONE pulse.
- Reset mid-operation:
  - A pending or granted host access in H_DONE is dropped with no H_ACK; the host must reissue.
  - A memory write already strobed is not undone.

Optional Feature:
- ARB_STATS_EN defined:
  - Adds output STAT_CONFLICT [15:0]: counts cycles with C_REQ & host_eligible, saturating at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - owner enum {OWN_NONE, OWN_CPU_RD, OWN_HOST};
  - host FSM enum {H_IDLE, H_DONE};
  - constants RW_READ=1'b1, RW_WRITE=1'b0.
- Sub-module dmem_arb_starve_ctr: parameterised saturating counter with inc/clr/at_max outputs.
- Grant mux and FSM stay in dmem_arbiter.

Test Plan:
- CPU-only traffic:
  - Preload DMEM[0]=5, DMEM[1]=50.
  - CPU reads addr 1 -> C_WAIT=0, next cycle C_VALID=1, C_RD=50.
  - CPU writes 4 to addr 0 -> DMEM[0]=4.
- Host-only traffic:
  - Host writes 16'h00AA to addr 7 -> H_ACK one cycle later.
  - Host reads addr 7 -> H_ACK with H_RD=16'h00AA; no second grant during the H_DONE cycle.
- Contention with MAX_WAIT=4:
  - CPU requests every cycle; host requests from cycle 0.
  - Host granted exactly at cycle 4; C_WAIT=1 only that cycle; H_ACK at cycle 5.
- MAX_WAIT=0 with simultaneous requests -> host granted first; CPU C_WAIT=1 for one cycle, then issued.
- Reset mid-operation:
  - RST low during H_DONE -> H_ACK stays 0, M_EN=0 immediately, cnt=0.
  - After release, a reissued host read completes normally.
- ARB_STATS_EN: 10 conflict cycles -> STAT_CONFLICT=10. Force 65540 conflict cycles -> STAT_CONFLICT holds 16'hFFFF.
